// File: rtl/dbus_console_resp_if.sv
// Data-bus and TX byte-stream bundle for dbus_console_resp.
// The master modport drives the bus and the stream's ready; slave is the responder side.
interface dbus_console_resp_if;
    logic [31:0] addr;
    logic        re;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;

    modport master (
        output addr, re, wr, wdata, tx_ready,
        input  rdata, sel, tx_valid, tx_byte
    );

    modport slave (
        input  addr, re, wr, wdata, tx_ready,
        output rdata, sel, tx_valid, tx_byte
    );
endinterface

// File: rtl/dbus_console_resp.sv
// Memory-mapped console responder: TXDATA/STATUS/CTRL/CYCLE registers and a TX byte FIFO
// drained over valid/ready. Define CONSOLE_DISPLAY_EN to echo drained bytes in simulation.
module dbus_console_resp #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          DATA_BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_console_resp_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_n, rd_ptr_n;
    logic [CNT_W-1:0]    count_r, count_n;
    logic                enable_r, enable_n;
    logic                overflow_r, overflow_n;
    logic                tx_valid_r, tx_valid_n;
    logic [7:0]          tx_byte_r, tx_byte_n;
    logic [31:0]         cycle_r;

    logic                sel_s, wr_sel_s, push_s, status_wr_s, ctrl_wr_s, flush_s;
    logic                pop_s, full_s, empty_s, push_ok_s, overflow_set_s;
    logic [1:0]          reg_idx_s;
    logic [7:0]          count_byte_s;
    logic [DATA_BUS_WIDTH-1:0] rdata_s;
    logic                unused_s;

    assign sel_s       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx_s   = bus.addr[3:2];
    assign wr_sel_s    = sel_s && bus.wr;
    assign push_s      = wr_sel_s && (reg_idx_s == 2'd0);
    assign status_wr_s = wr_sel_s && (reg_idx_s == 2'd1);
    assign ctrl_wr_s   = wr_sel_s && (reg_idx_s == 2'd2);
    assign flush_s     = ctrl_wr_s && bus.wdata[1];

    assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s     = (count_r == CNT_W'(0));
    // A flush discards any pop that lands on the same edge.
    assign pop_s          = tx_valid_r && bus.tx_ready && !flush_s;
    assign push_ok_s      = push_s && (!full_s || pop_s);
    assign overflow_set_s = push_s && full_s && !pop_s;
    assign count_byte_s   = 8'(count_r);
    assign unused_s       = ^{bus.addr[1:0], bus.wdata[31:8]};

    // Next-state for pointers, count, control bits and the registered stream outputs.
    always_comb begin
        wr_ptr_n   = wr_ptr_r;
        rd_ptr_n   = rd_ptr_r;
        count_n    = count_r;
        enable_n   = enable_r;
        overflow_n = overflow_r;
        if (flush_s) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_n = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_n = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_n = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_n = rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_n = count_r + CNT_W'(1);
                2'b01:   count_n = count_r - CNT_W'(1);
                default: count_n = count_r;
            endcase
        end
        if (ctrl_wr_s) begin
            enable_n = bus.wdata[0];
        end else begin
            enable_n = enable_r;
        end
        if (overflow_set_s) begin
            overflow_n = 1'b1;
        end else if (status_wr_s && bus.wdata[2]) begin
            overflow_n = 1'b0;
        end else begin
            overflow_n = overflow_r;
        end
        tx_valid_n = enable_n && (count_n != CNT_W'(0));
        // The new head may be the byte being written this very edge.
        if (push_ok_s && (wr_ptr_r == rd_ptr_n)) begin
            tx_byte_n = bus.wdata[7:0];
        end else begin
            tx_byte_n = mem_r[rd_ptr_n];
        end
    end

    // Register state; reset release is expected to arrive already synchronised to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            enable_r   <= 1'b1;
            overflow_r <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_byte_r  <= 8'h00;
            cycle_r    <= 32'h0000_0000;
        end else begin
            wr_ptr_r   <= wr_ptr_n;
            rd_ptr_r   <= rd_ptr_n;
            count_r    <= count_n;
            enable_r   <= enable_n;
            overflow_r <= overflow_n;
            tx_valid_r <= tx_valid_n;
            tx_byte_r  <= tx_byte_n;
            cycle_r    <= cycle_r + 32'd1;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= bus.wdata[7:0];
        end
    end

    // Zero-wait-state read mux; values are the pre-edge register contents.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (sel_s && bus.re) begin
            case (reg_idx_s)
                2'd0:    rdata_s = 32'h0000_0000;
                2'd1:    rdata_s = {16'h0000, count_byte_s, 5'b00000, overflow_r, empty_s, full_s};
                2'd2:    rdata_s = {31'h0000_0000, enable_r};
                2'd3:    rdata_s = cycle_r;
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.rdata    = rdata_s;
    assign bus.sel      = sel_s;
    assign bus.tx_valid = tx_valid_r;
    assign bus.tx_byte  = tx_byte_r;

`ifdef CONSOLE_DISPLAY_EN
    // Simulation echo of drained bytes and overflow events.
    always @(posedge clk) begin
        if (reset && tx_valid_r && bus.tx_ready) begin
            $write("%c", tx_byte_r);
        end
        if (reset && overflow_set_s && !overflow_r) begin
            $write("\n[console] warning: TX overflow at cycle %0d\n", cycle_r);
        end
    end
`endif

endmodule

// File: tb/tb_dbus_console_resp.sv
// Directed, table-driven bench for dbus_console_resp: register map, FIFO, handshake, flush, reset.
module tb_dbus_console_resp;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;
    localparam logic [31:0] A_CY = BASE + 32'hC;

    typedef struct {
        logic        wr;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic        chk_byte;
        logic [7:0]  exp_byte;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    dbus_console_resp_if bus_if ();

    dbus_console_resp #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(8), .DATA_BUS_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bus_if.wr       = w;
        bus_if.re       = r;
        bus_if.addr     = a;
        bus_if.wdata    = d;
        bus_if.tx_ready = rdy;
    endtask

    function automatic void add(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                                input logic rdy, input logic chk_rd, input logic [31:0] exp_rd,
                                input logic ev, input logic [7:0] eb);
        vec_t v;
        v.wr = w; v.re = r; v.addr = a; v.wdata = d; v.rdy = rdy;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        v.exp_valid = ev; v.chk_byte = ev; v.exp_byte = eb;
        vecs.push_back(v);
    endfunction

    // Shorthands: write, read, idle (stream-only) vectors.
    function automatic void w_(input logic [31:0] a, input logic [31:0] d, input logic rdy, input logic ev, input logic [7:0] eb);
        add(1'b1, 1'b0, a, d, rdy, 1'b0, 32'h0, ev, eb);
    endfunction
    function automatic void r_(input logic [31:0] a, input logic rdy, input logic [31:0] e, input logic ev, input logic [7:0] eb);
        add(1'b0, 1'b1, a, 32'h0, rdy, 1'b1, e, ev, eb);
    endfunction
    function automatic void i_(input logic rdy, input logic ev, input logic [7:0] eb);
        add(1'b0, 1'b0, A_TX, 32'h0, rdy, 1'b0, 32'h0, ev, eb);
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Two 0x41/0x42 writes with ready high
        w_(A_TX, 32'h41, 1'b1, 1'b0, 8'h00);
        w_(A_TX, 32'h42, 1'b1, 1'b1, 8'h41);
        i_(1'b1, 1'b1, 8'h42);
        r_(A_ST, 1'b1, 32'h0000_0002, 1'b0, 8'h00);

        // Overflow: ten bytes into eight entries, then drain
        for (int i = 0; i < 10; i++) begin
            w_(A_TX, 32'h30 + 32'(i), 1'b0, (i != 0), 8'h30);
        end
        r_(A_ST, 1'b0, 32'h0000_0805, 1'b1, 8'h30);
        for (int i = 0; i < 8; i++) begin
            i_(1'b1, 1'b1, 8'h30 + 8'(i));
        end
        r_(A_ST, 1'b1, 32'h0000_0006, 1'b0, 8'h00);
        w_(A_ST, 32'h4, 1'b1, 1'b0, 8'h00);
        r_(A_ST, 1'b1, 32'h0000_0002, 1'b0, 8'h00);

        // Disable with three queued bytes, then re-enable
        w_(A_TX, 32'h61, 1'b0, 1'b0, 8'h00);
        w_(A_TX, 32'h62, 1'b0, 1'b1, 8'h61);
        w_(A_TX, 32'h63, 1'b0, 1'b1, 8'h61);
        r_(A_TX, 1'b0, 32'h0000_0000, 1'b1, 8'h61);
        w_(A_CT, 32'h0, 1'b0, 1'b1, 8'h61);
        r_(A_ST, 1'b0, 32'h0000_0300, 1'b0, 8'h00);
        r_(A_CT, 1'b1, 32'h0000_0000, 1'b0, 8'h00);
        r_(A_ST, 1'b1, 32'h0000_0300, 1'b0, 8'h00);
        w_(A_CT, 32'h1, 1'b0, 1'b0, 8'h00);
        i_(1'b1, 1'b1, 8'h61);
        i_(1'b1, 1'b1, 8'h62);
        i_(1'b1, 1'b1, 8'h63);
        r_(A_ST, 1'b1, 32'h0000_0002, 1'b0, 8'h00);

        // Full FIFO with simultaneous push+pop; 0x55 comes out last
        for (int i = 0; i < 8; i++) begin
            w_(A_TX, 32'h70 + 32'(i), 1'b0, (i != 0), 8'h70);
        end
        w_(A_TX, 32'h55, 1'b1, 1'b1, 8'h70);
        r_(A_ST, 1'b0, 32'h0000_0801, 1'b1, 8'h71);
        for (int i = 1; i < 8; i++) begin
            i_(1'b1, 1'b1, 8'h70 + 8'(i));
        end
        i_(1'b1, 1'b1, 8'h55);
        r_(A_ST, 1'b1, 32'h0000_0002, 1'b0, 8'h00);

        // Read+write same cycle shows pre-edge value; out-of-window accesses ignored
        add(1'b1, 1'b1, A_CT, 32'h0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 8'h00);
        r_(A_CT, 1'b0, 32'h0000_0000, 1'b0, 8'h00);
        w_(A_CT, 32'h1, 1'b0, 1'b0, 8'h00);
        r_(32'h0000_2004, 1'b0, 32'h0000_0000, 1'b0, 8'h00);
        w_(32'h0000_2000, 32'h99, 1'b0, 1'b0, 8'h00);
        r_(A_ST, 1'b0, 32'h0000_0002, 1'b0, 8'h00);

        // Flush with a simultaneous pop, then the FIFO restarts cleanly
        w_(A_TX, 32'h11, 1'b0, 1'b0, 8'h00);
        w_(A_TX, 32'h12, 1'b0, 1'b1, 8'h11);
        w_(A_CT, 32'h3, 1'b1, 1'b1, 8'h11);
        r_(A_ST, 1'b1, 32'h0000_0002, 1'b0, 8'h00);
        r_(A_CT, 1'b1, 32'h0000_0001, 1'b0, 8'h00);
        w_(A_TX, 32'h13, 1'b1, 1'b0, 8'h00);
        i_(1'b1, 1'b1, 8'h13);
        r_(A_ST, 1'b1, 32'h0000_0002, 1'b0, 8'h00);

        // Reset for two cycles, release between edges
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, A_CY, 32'h0, 1'b0);
        #1 check("reset_cycle", 0, bus_if.rdata, 32'h0000_0002);
        drive(1'b0, 1'b1, A_ST, 32'h0, 1'b0);
        #1 check("reset_status", 0, bus_if.rdata, 32'h0000_0002);
        drive(1'b0, 1'b1, A_CT, 32'h0, 1'b0);
        #1 check("reset_ctrl", 0, bus_if.rdata, 32'h0000_0001);
        check("reset_valid", 0, 32'(bus_if.tx_valid), 32'h0);
        check("reset_byte", 0, 32'(bus_if.tx_byte), 32'h0);
        check("reset_sel", 0, 32'(bus_if.sel), 32'h1);
        @(posedge clk);
        #1;

        // Table pass
        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
            #1;
            if (vecs[i].chk_rd) check("rdata", i, bus_if.rdata, vecs[i].exp_rd);
            check("tx_valid", i, 32'(bus_if.tx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_byte) check("tx_byte", i, 32'(bus_if.tx_byte), 32'(vecs[i].exp_byte));
            @(posedge clk);
            #1;
        end

        // Reset mid-drain with five bytes queued
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, A_TX, 32'hA0 + 32'(i), 1'b0);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, A_TX, 32'h0, 1'b1);
        #1 check("md_valid", 0, 32'(bus_if.tx_valid), 32'h1);
        check("md_byte", 0, 32'(bus_if.tx_byte), 32'hA0);
        @(posedge clk);
        #1 check("md_byte", 1, 32'(bus_if.tx_byte), 32'hA1);
        #2 reset = 1'b0;
        #1 check("md_async_valid", 0, 32'(bus_if.tx_valid), 32'h0);
        check("md_async_byte", 0, 32'(bus_if.tx_byte), 32'h0);
        drive(1'b0, 1'b0, A_TX, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, A_ST, 32'h0, 1'b1);
        #1 check("md_status", 0, bus_if.rdata, 32'h0000_0002);
        drive(1'b0, 1'b1, A_CY, 32'h0, 1'b1);
        #1 check("md_cycle", 0, bus_if.rdata, 32'h0000_0000);
        check("md_valid", 1, 32'(bus_if.tx_valid), 32'h0);
        @(posedge clk);
        #1 check("md_cycle", 1, bus_if.rdata, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
